// File: rtl/reg_write_arb_pkg.sv
// Shared encodings and defaults for the round-robin register write arbiter.
// REG_WRITE_ARB_LOCK_EN (defined by the build) enables the burst-lock HOLD path.
package reg_write_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int WIDTH_DEF    = 8;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/reg_write_arb_rr_pick.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  int c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/reg_write_arb.sv
// Round-robin arbiter driving the wen/D of one external shared register.
// Define REG_WRITE_ARB_LOCK_EN to add the lock port and HOLD burst state.
module reg_write_arb
  import reg_write_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] din,
`ifdef REG_WRITE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     wen,
  output logic [WIDTH-1:0]         d_out,
  output logic                     busy,
  output logic [1:0]               dbg_state,
  output logic [PTR_W-1:0]         dbg_ptr
);

  // Handshake: a requester holds req (and its din) high until it observes its
  // gnt pulse; a req dropped before that is simply forgotten.
  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                wen_q, wen_d;
  logic [WIDTH-1:0]    d_out_q, d_out_d;
  logic                regrant;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;

`ifdef REG_WRITE_ARB_LOCK_EN
  localparam logic [3:0] MAX_HOLD_W = 4'(MAX_HOLD);
  logic [3:0]          hold_cnt_q, hold_cnt_d;
  logic [PTR_W-1:0]    hold_idx_q, hold_idx_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    wen_d   = 1'b0;
    d_out_d = d_out_q;
    regrant = 1'b0;
`ifdef REG_WRITE_ARB_LOCK_EN
    hold_cnt_d = hold_cnt_q;
    hold_idx_d = hold_idx_q;
    // ptr already points past the owner, so falling out of HOLD rotates normally.
    if (state_q == ST_HOLD && req[hold_idx_q] && lock[hold_idx_q] &&
        hold_cnt_q < MAX_HOLD_W) begin
      regrant            = 1'b1;
      gnt_d[hold_idx_q]  = 1'b1;
      wen_d              = 1'b1;
      d_out_d            = din[hold_idx_q*WIDTH +: WIDTH];
      hold_cnt_d         = hold_cnt_q + 4'd1;
    end
`endif
    if (!regrant) begin
      if (pick_valid) begin
        gnt_d   = pick_gnt;
        wen_d   = 1'b1;
        d_out_d = din[pick_idx*WIDTH +: WIDTH];
        ptr_d   = (pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : pick_idx + PTR_W'(1);
        state_d = ST_GRANT;
`ifdef REG_WRITE_ARB_LOCK_EN
        hold_cnt_d = '0;
        if (lock[pick_idx] && MAX_HOLD > 1) begin
          state_d    = ST_HOLD;
          hold_idx_d = pick_idx;
          hold_cnt_d = 4'd1;
        end
`endif
      end else begin
        state_d = ST_IDLE;
`ifdef REG_WRITE_ARB_LOCK_EN
        hold_cnt_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wen_q   <= 1'b0;
      d_out_q <= '0;
`ifdef REG_WRITE_ARB_LOCK_EN
      hold_cnt_q <= '0;
      hold_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wen_q   <= wen_d;
      d_out_q <= d_out_d;
`ifdef REG_WRITE_ARB_LOCK_EN
      hold_cnt_q <= hold_cnt_d;
      hold_idx_q <= hold_idx_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign wen       = wen_q;
  assign d_out     = d_out_q;
  assign busy      = (state_q == ST_GRANT) || (state_q == ST_HOLD);
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_reg_write_arb.sv
// Directed bench for reg_write_arb (NUM_REQ=4, WIDTH=8); lock vectors run only
// when REG_WRITE_ARB_LOCK_EN is defined.
module tb_reg_write_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
`ifdef REG_WRITE_ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  gnt;
  logic        wen;
  logic [7:0]  d_out;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  data_of[4];

  // clock / reset
  always #5 clk = ~clk;

  reg_write_arb #(.NUM_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
`ifdef REG_WRITE_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .wen       (wen),
    .d_out     (d_out),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: advance one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    din = {8'h44, 8'hA5, 8'h22, 8'h11};
    data_of[0] = 8'h11; data_of[1] = 8'h22; data_of[2] = 8'hA5; data_of[3] = 8'h44;
    req = '0;
    rst = 1'b1;
`ifdef REG_WRITE_ARB_LOCK_EN
    lock = '0;
`endif
    step();
    check("rst_gnt",   32'(gnt), 0);
    check("rst_wen",   32'(wen), 0);
    check("rst_dout",  32'(d_out), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ptr",   32'(dbg_ptr), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // single request on requester 2
    req = 4'b0100;
    step();
    check("single_gnt",   32'(gnt), 32'h4);
    check("single_wen",   32'(wen), 1);
    check("single_dout",  32'(d_out), 32'hA5);
    check("single_ptr",   32'(dbg_ptr), 3);
    check("single_busy",  32'(busy), 1);
    check("single_state", 32'(dbg_state), 1);
    req = '0;
    step();
    check("idle_gnt",   32'(gnt), 0);
    check("idle_wen",   32'(wen), 0);
    check("idle_dout",  32'(d_out), 32'hA5);
    check("idle_state", 32'(dbg_state), 0);
    check("idle_busy",  32'(busy), 0);
    check("idle_ptr",   32'(dbg_ptr), 3);

    // wrap from ptr=3: requester 3 first, then 0
    req = 4'b1001;
    step();
    check("wrap_gnt3",  32'(gnt), 32'h8);
    check("wrap_dout3", 32'(d_out), 32'h44);
    req = 4'b0001;
    step();
    check("wrap_gnt0",  32'(gnt), 32'h1);
    check("wrap_dout0", 32'(d_out), 32'h11);
    check("wrap_ptr",   32'(dbg_ptr), 1);
    req = '0;
    step();
    check("wrap_wen_off", 32'(wen), 0);

    // all four held: strict rotation 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(1 << (i % 4)));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      step();
      e = exp_q.pop_front();
      check("rr_gnt",  32'(gnt), e);
      check("rr_wen",  32'(wen), 1);
      check("rr_dout", 32'(d_out), 32'(data_of[i % 4]));
    end

    // reset in the middle of granting aborts everything
    rst = 1'b1;
    step();
    check("mid_rst_gnt",  32'(gnt), 0);
    check("mid_rst_wen",  32'(wen), 0);
    check("mid_rst_dout", 32'(d_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h1);

    // requester 3 pulses while 0 wins; it must be dropped
    do_reset();
    req = 4'b1001;
    step();
    check("drop_gnt0", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    check("drop_gnt",  32'(gnt), 0);
    check("drop_wen",  32'(wen), 0);
    step();
    check("drop_late", 32'(gnt), 0);

`ifdef REG_WRITE_ARB_LOCK_EN
    // move ptr to 1, then lock requester 1 against a competing requester 0
    do_reset();
    req = 4'b0001;
    step();
    check("lk_pre_gnt", 32'(gnt), 32'h1);
    req  = 4'b0011;
    lock = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("lk_hold_gnt", 32'(gnt), 32'h2);
      check("lk_hold_st",  32'(dbg_state), 2);
    end
    step();
    check("lk_exit_gnt", 32'(gnt), 32'h1);
    check("lk_exit_ptr", 32'(dbg_ptr), 1);
    req  = '0;
    lock = '0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arb.md
REG_WRITE_ARB -- requirements
Module: reg_write_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one register write port (2..8).
REQ-002 Parameter WIDTH, default 8, data width of the shared register.
REQ-003 Parameter MAX_HOLD, default 4, max consecutive grants in a locked burst (1..15).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester write request.
REQ-007 din  input  NUM_REQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  NUM_REQ  registered one-hot grant, one-cycle pulse per accepted write.
REQ-009 wen  output  1  registered write enable to shared register; equals OR of gnt.
REQ-010 d_out  output  WIDTH  registered write data of granted requester, to register D.
REQ-011 busy  output  1  high while FSM is in GRANT or HOLD.
REQ-012 lock  input  NUM_REQ  burst-lock request (present only with REG_WRITE_ARB_LOCK_EN).

Function
REQ-013 FSM states SHALL be IDLE, GRANT, HOLD.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer ptr, first asserted req at or after ptr (wrapping modulo NUM_REQ) wins.
REQ-015 Latency SHALL be one cycle: req sampled at edge t drives gnt/wen/d_out valid in cycle t+1.
REQ-016 After a grant to i, ptr SHALL become (i+1) mod NUM_REQ; ptr SHALL NOT change in cycles with no grant.
REQ-017 IDLE -> GRANT when any req asserted; GRANT -> GRANT while any req asserted; GRANT -> IDLE when no req asserted.
REQ-018 Requester SHALL keep req high until it sees gnt; arbiter SHALL grant a held req again only by normal rotation (no starvation: every asserted req granted within NUM_REQ grants).
REQ-019 d_out SHALL hold its last value when wen is low.
REQ-020 A req deasserted before its grant SHALL be dropped without a grant.

Reset
REQ-021 On rst: gnt=0, wen=0, d_out=0, busy=0, ptr=0, hold counter=0, state=IDLE, at next rising edge.
REQ-022 rst mid-burst or mid-grant SHALL abort immediately; no grant issued in the cycle following reset edge.

Configuration
REQ-023 Macro REG_WRITE_ARB_LOCK_EN SHALL compile in the lock port and HOLD state.
REQ-024 With macro: winner i with lock[i] high enters HOLD; HOLD regrants i each cycle while req[i]&&lock[i], counting grants; at MAX_HOLD grants or lock/req drop, exit to normal arbitration that cycle with ptr=(i+1) mod NUM_REQ.
REQ-025 Without macro: lock port absent, HOLD unreachable, behaviour as REQ-013..020 only.

Structure
REQ-026 Shared package/include SHALL hold state encodings (IDLE=2'd0, GRANT=2'd1, HOLD=2'd2) and NUM_REQ/WIDTH defaults.
REQ-027 Sub-module rr_pick SHALL implement combinational round-robin pick (req, ptr -> one-hot winner, valid).
REQ-028 Block SHALL contain no storage of the shared register itself; it drives an external register's wen/D.

Verification
REQ-029 Single req[2]=1, din[2]=8'hA5 -> next cycle gnt=4'b0100, wen=1, d_out=8'hA5, ptr=3.
REQ-030 req=4'b1111 held 8 cycles from reset -> grants 0,1,2,3,0,1,2,3 in consecutive cycles, wen continuously 1.
REQ-031 ptr=3, req=4'b1001 -> gnt=4'b1000 then 4'b0001.
REQ-032 Lock build, MAX_HOLD=4, req[1]&lock[1] held plus req[0] -> gnt[1] four cycles, then gnt[0].
REQ-033 rst asserted during GRANT with req=4'b1111 -> next cycle gnt=0, wen=0, d_out=0, busy=0; first post-reset grant to requester 0.
REQ-034 req pulsed 0 -> 1 -> 0 on requester 3 with requester 0 granted same cycle -> requester 3 receives no grant, wen returns 0.
